// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and image framing constants for the boot loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_RUN, S_ERROR} state_t;
    localparam int HDR_BYTES = 4;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: little-endian byte-to-word packer; word_done flags the cycle the 4th byte is accepted.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0]  idx;
    logic [23:0] sr;
    // The 4th byte is combined combinationally so callers can act on it at the accepting edge.
    assign word = {in_data, sr};
    assign word_done = en && (idx == 2'(BYTES_PER_WORD - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            sr  <= '0;
        end else if (clear) begin
            idx <= '0;
            sr  <= '0;
        end else if (en) begin
            idx <= idx + 2'd1;
            sr  <= {in_data, sr[23:8]};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian program image into instruction RAM, then releases the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;
    state_t state, state_nx;
    logic [ADDR_W:0] cnt, n_words;
    logic [31:0] word;
    logic take, asm_en, clr, word_done, oversize;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic last_word;
    assign last_word = (cnt + (ADDR_W + 1)'(1)) == n_words;
`endif
    assign in_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign cpu_reset = state != S_RUN;
    assign done      = state == S_RUN;
    assign error     = state == S_ERROR;
    assign take      = in_valid && in_ready;
    // Once all N words are in (cnt == n_words) DATA only waits for the final write to commit.
    assign asm_en    = take && (state == S_HDR || (state == S_DATA && cnt != n_words));
    assign clr       = reload && (state == S_RUN || state == S_ERROR);
    assign oversize  = {1'b0, word} > MAX_WORDS;

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr),
        .en        (asm_en),
        .in_data   (in_data),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_HDR: if (word_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_nx = oversize ? S_ERROR : (word == 32'd0) ? S_CSUM : S_DATA;
`else
                state_nx = oversize ? S_ERROR : S_DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_DATA: if (word_done && last_word) state_nx = S_CSUM;
            S_CSUM: if (take) state_nx = (in_data == csum) ? S_RUN : S_ERROR;
`else
            S_DATA: if (cnt == n_words) state_nx = S_RUN;
`endif
            S_RUN, S_ERROR: if (reload) state_nx = S_HDR;
            default: state_nx = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_HDR;
            cnt        <= '0;
            n_words    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
        end else begin
            state   <= state_nx;
            imem_we <= word_done && state == S_DATA;
            if (clr) cnt <= '0;
            else if (word_done && state == S_DATA) cnt <= cnt + (ADDR_W + 1)'(1);
            if (word_done && state == S_HDR) n_words <= word[ADDR_W:0];
            if (word_done && state == S_DATA) begin
                imem_addr  <= BASE_ADDR + 32'({cnt, 2'b00});
                imem_wdata <= word;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) csum <= '0;
        else if (clr) csum <= '0;
        else if (asm_en) csum <= csum ^ in_data;
    end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized image loads checked against a list-of-writes reference model.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, reload = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, imem_we, cpu_reset, done, error;
    logic [31:0] imem_addr, imem_wdata;
    int checks = 0, failures = 0;
    logic [31:0] words_q[$], wa[$], wd[$];
    logic [7:0] bytes_q[$];
    logic [7:0] exp_csum;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (imem_we) begin
        wa.push_back(imem_addr);
        wd.push_back(imem_wdata);
    end

    task automatic rand_words(input int n);
        words_q = {};
        for (int k = 0; k < n; k++) words_q.push_back($urandom);
    endtask

    // Serialize: LE count, LE words, then the XOR of every byte when checksum is compiled in.
    task automatic build(input logic [31:0] n, input bit flip);
        logic [7:0] x;
        x = 8'h00;
        bytes_q = {};
        for (int b = 0; b < 4; b++) bytes_q.push_back(n[8*b +: 8]);
        foreach (words_q[k]) for (int b = 0; b < 4; b++) bytes_q.push_back(words_q[k][8*b +: 8]);
        foreach (bytes_q[k]) x ^= bytes_q[k];
        exp_csum = x ^ {7'd0, flip};
`ifdef IMEM_LOADER_CHECKSUM_EN
        bytes_q.push_back(exp_csum);
`endif
    endtask

    // mode 0: valid held, 1: valid every other cycle, 2: random valid. Returns at the negedge after the last accept.
    task automatic drive(input int count, input int mode);
        int i, g;
        bit acc;
        i = 0;
        g = 0;
        while (i < count && g < 20000) begin
            @(negedge clk);
            g++;
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? g[0] : ($urandom_range(0, 1) == 1);
            in_data = bytes_q[i];
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
        end
        checks++;
        if (i < count) begin
            failures++;
            $display("FAIL drive_timeout accepted=%0d required=%0d", i, count);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reload_state in_ready=%b cpu_reset=%b done=%b error=%b required 1 1 0 0",
                     in_ready, cpu_reset, done, error);
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 4 && done !== 1'b1; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || imem_we !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl in_ready=%b cpu_reset=%b we=%b done=%b error=%b required 1 1 0 0 0",
                     in_ready, cpu_reset, imem_we, done, error);
        end
        checks++;
        if (imem_addr !== BASE || imem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus addr=%h wdata=%h required %h 00000000", imem_addr, imem_wdata, BASE);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b cpu_reset=%b done=%b", in_ready, cpu_reset, done);
        end
    endtask

    task automatic test_back_to_back();
        words_q = {32'h2001_0005, 32'h0000_0008};
        wa = {};
        wd = {};
        build(32'd2, 1'b0);
        drive(bytes_q.size(), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release done=%b cpu_reset=%b required 1 0", done, cpu_reset);
        end
`else
        checks++;
        if (imem_we !== 1'b1 || cpu_reset !== 1'b1 || imem_addr !== BASE + 32'd4 || imem_wdata !== 32'h8) begin
            failures++;
            $display("FAIL b2b_last_write we=%b cpu_reset=%b addr=%h data=%h required 1 1 %h 00000008",
                     imem_we, cpu_reset, imem_addr, imem_wdata, BASE + 32'd4);
        end
        @(negedge clk);
        checks++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release cpu_reset=%b done=%b we=%b in_ready=%b required 0 1 0 0",
                     cpu_reset, done, imem_we, in_ready);
        end
`endif
        #1;
        checks++;
        if (wa.size() !== 2) begin
            failures++;
            $display("FAIL b2b_write_count got=%0d required=2", wa.size());
        end
        foreach (words_q[k]) begin
            checks++;
            if (k >= wa.size() || wa[k] !== BASE + 32'(4 * k) || wd[k] !== words_q[k]) begin
                failures++;
                $display("FAIL b2b_write[%0d] required addr=%h data=%h", k, BASE + 32'(4 * k), words_q[k]);
            end
        end
        pulse_reload();
    endtask

    task automatic test_toggle(input int mode, input int n);
        if (n < 0) words_q = {32'h2001_0005, 32'h0000_0008};
        else rand_words(n);
        wa = {};
        wd = {};
        build(32'(words_q.size()), 1'b0);
        drive(bytes_q.size(), mode);
        wait_done();
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL gap%0d_release done=%b cpu_reset=%b required 1 0", mode, done, cpu_reset);
        end
        #1;
        checks++;
        if (wa.size() !== words_q.size()) begin
            failures++;
            $display("FAIL gap%0d_write_count got=%0d required=%0d", mode, wa.size(), words_q.size());
        end
        foreach (words_q[k]) begin
            checks++;
            if (k >= wa.size() || wa[k] !== BASE + 32'(4 * k) || wd[k] !== words_q[k]) begin
                failures++;
                $display("FAIL gap%0d_write[%0d] required addr=%h data=%h", mode, k, BASE + 32'(4 * k), words_q[k]);
            end
        end
        pulse_reload();
    endtask

    task automatic test_zero_count();
        words_q = {};
        wa = {};
        wd = {};
        build(32'd0, 1'b0);
        drive(bytes_q.size(), 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        checks++;
        if (done !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL zero_early done=%b cpu_reset=%b required 0 1", done, cpu_reset);
        end
        @(negedge clk);
`endif
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL zero_release done=%b cpu_reset=%b required 1 0", done, cpu_reset);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (wa.size() !== 0) begin
            failures++;
            $display("FAIL zero_writes got=%0d required=0", wa.size());
        end
        pulse_reload();
    endtask

    task automatic test_oversize();
        words_q = {};
        wa = {};
        wd = {};
        build(32'((1 << ADDR_W) + 1), 1'b0);
        drive(4, 0);
        checks++;
        if (error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL oversize_state error=%b cpu_reset=%b in_ready=%b done=%b required 1 1 0 0",
                     error, cpu_reset, in_ready, done);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wa.size() !== 0 || error !== 1'b1) begin
            failures++;
            $display("FAIL oversize_hold writes=%0d error=%b required 0 1", wa.size(), error);
        end
        pulse_reload();
        rand_words(1);
        build(32'd1, 1'b0);
        drive(bytes_q.size(), 0);
        wait_done();
        #1;
        checks++;
        if (done !== 1'b1 || wa.size() !== 1 || wa[0] !== BASE || wd[0] !== words_q[0]) begin
            failures++;
            $display("FAIL oversize_recover done=%b writes=%0d required done=1 one write addr=%h data=%h",
                     done, wa.size(), BASE, words_q[0]);
        end
        pulse_reload();
    endtask

    task automatic test_max_count();
        int bad;
        rand_words(1 << ADDR_W);
        wa = {};
        wd = {};
        build(32'(1 << ADDR_W), 1'b0);
        drive(bytes_q.size(), 0);
        wait_done();
        #1;
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || wa.size() !== (1 << ADDR_W)) begin
            failures++;
            $display("FAIL max_count done=%b error=%b writes=%0d required 1 0 %0d", done, error, wa.size(), 1 << ADDR_W);
        end
        bad = 0;
        foreach (words_q[k]) if (k >= wa.size() || wa[k] !== BASE + 32'(4 * k) || wd[k] !== words_q[k]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL max_count_data wrong_writes=%0d required=0", bad);
        end
        pulse_reload();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        rand_words(3);
        build(32'd3, 1'b0);
        drive(bytes_q.size(), 2);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL csum_good done=%b error=%b required 1 0 (csum=%h)", done, error, exp_csum);
        end
        pulse_reload();
        build(32'd3, 1'b1);
        drive(bytes_q.size(), 0);
        checks++;
        if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL csum_bad error=%b cpu_reset=%b done=%b in_ready=%b required 1 1 0 0",
                     error, cpu_reset, done, in_ready);
        end
        pulse_reload();
    endtask
`endif

    task automatic test_reset_midload();
        rand_words(3);
        build(32'd3, 1'b0);
        drive(9, 0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cpu_reset !== 1'b1 || in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== BASE || done !== 1'b0) begin
            failures++;
            $display("FAIL midload_reset cpu_reset=%b in_ready=%b we=%b addr=%h done=%b required 1 1 0 %h 0",
                     cpu_reset, in_ready, imem_we, imem_addr, done, BASE);
        end
        @(negedge clk);
        reset = 1'b0;
        wa = {};
        wd = {};
        rand_words(4);
        build(32'd4, 1'b0);
        drive(bytes_q.size(), 2);
        wait_done();
        #1;
        checks++;
        if (done !== 1'b1 || wa.size() !== 4) begin
            failures++;
            $display("FAIL midload_reload done=%b writes=%0d required 1 4", done, wa.size());
        end
        foreach (words_q[k]) begin
            checks++;
            if (k >= wa.size() || wa[k] !== BASE + 32'(4 * k) || wd[k] !== words_q[k]) begin
                failures++;
                $display("FAIL midload_write[%0d] required addr=%h data=%h", k, BASE + 32'(4 * k), words_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle(1, -1);
        test_toggle(2, 6);
        test_zero_count();
        test_oversize();
        test_max_count();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
